// File: rtl/countdown_zero_timer_if.sv
// Control/status bundle for countdown_zero_timer: load/enable inputs and count/flag outputs.
interface countdown_zero_timer_if #(
    parameter int WIDTH = 8
);
    logic             LOAD;
    logic             EN;
    logic             RELOAD_EN;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             ZERO;
    logic             DONE;
    logic             BUSY;

    modport master (
        output LOAD, EN, RELOAD_EN, D,
        input  Q, ZERO, DONE, BUSY
    );

    modport slave (
        input  LOAD, EN, RELOAD_EN, D,
        output Q, ZERO, DONE, BUSY
    );
endinterface

// File: rtl/countdown_zero_timer.sv
// Loadable down-counter with registered zero flag, terminal-count pulse and
// optional auto-reload. All outputs come straight from flops.
//
// state  | meaning
// IDLE   | stopped, count holds (normally 0), EN ignored
// RUN    | counting down on EN
// EXPIRE | one-shot terminal count just reached, returns to IDLE next cycle
module countdown_zero_timer #(
    parameter int WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    countdown_zero_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        if (bus.LOAD) begin
            // Load wins over EN, so a terminal count in this cycle is dropped.
            q_d     = bus.D;
            r_d     = bus.D;
            state_d = (bus.D != '0) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.EN) begin
                        if (q_q > WIDTH'(1)) begin
                            q_d = q_q - WIDTH'(1);
                        end else if (q_q == WIDTH'(1)) begin
                            done_d = 1'b1;
                            if (bus.RELOAD_EN) begin
                                q_d = r_q;
                            end else begin
                                q_d     = '0;
                                state_d = EXPIRE;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                EXPIRE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        zero_d = (q_d == '0);
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.ZERO = zero_q;
    assign bus.DONE = done_q;
    assign bus.BUSY = busy_q;
endmodule

// File: tb/tb_countdown_zero_timer.sv
// Directed bench for countdown_zero_timer: vector table plus reset and full-range sequences.
module tb_countdown_zero_timer;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    countdown_zero_timer_if #(.WIDTH(WIDTH)) bus ();

    countdown_zero_timer #(.WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       load;
        logic       en;
        logic       reload_en;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_zero;
        logic       exp_done;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic l, input logic e, input logic r, input int d,
                       input int q, input logic z, input logic dn, input logic b);
        vec_t v;
        v.load = l; v.en = e; v.reload_en = r; v.d = 8'(d);
        v.exp_q = 8'(q); v.exp_zero = z; v.exp_done = dn; v.exp_busy = b;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic l, input logic e, input logic r, input int d);
        bus.LOAD = l; bus.EN = e; bus.RELOAD_EN = r; bus.D = 8'(d);
    endtask

    initial begin
        int   cyc;
        int   prev_q;
        logic bad;

        drive(0, 0, 0, 0);
        rst = 1'b1;
        #12;
        chk("reset_q",    int'(bus.Q), 0);
        chk("reset_zero", int'(bus.ZERO), 1);
        chk("reset_done", int'(bus.DONE), 0);
        chk("reset_busy", int'(bus.BUSY), 0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        //  ld en re  d    q  z dn b
        // one-shot 3
        add(1, 0, 0, 3,   3, 0, 0, 1);
        add(0, 1, 0, 0,   2, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 0, 1);
        add(0, 1, 0, 0,   0, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 1, 0, 0);
        // gated enable 1,0,0,1,1,1
        add(1, 0, 0, 4,   4, 0, 0, 1);
        add(0, 1, 0, 0,   3, 0, 0, 1);
        add(0, 0, 0, 0,   3, 0, 0, 1);
        add(0, 0, 0, 0,   3, 0, 0, 1);
        add(0, 1, 0, 0,   2, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 0, 1);
        add(0, 1, 0, 0,   0, 1, 1, 0);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        // auto-reload period 2
        add(1, 0, 1, 2,   2, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            add(0, 1, 1, 0, 1, 0, 0, 1);
            add(0, 1, 1, 0, 2, 0, 1, 1);
        end
        add(0, 0, 0, 0,   2, 0, 0, 1);
        // load priority over terminal count
        add(0, 1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 1, 6,   6, 0, 0, 1);
        add(0, 1, 0, 0,   5, 0, 0, 1);
        // load zero, EN in IDLE
        add(1, 1, 0, 0,   0, 1, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0);
        add(0, 1, 1, 0,   0, 1, 0, 0);
        // reload with R == 1
        add(1, 0, 1, 1,   1, 0, 0, 1);
        add(0, 1, 1, 0,   1, 0, 1, 1);
        add(0, 1, 1, 0,   1, 0, 1, 1);
        add(0, 0, 1, 0,   1, 0, 0, 1);
        add(0, 1, 0, 0,   0, 1, 1, 0);
        // load in EXPIRE
        add(1, 0, 0, 2,   2, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 0, 1);
        add(0, 1, 0, 0,   0, 1, 1, 0);
        add(1, 1, 0, 1,   1, 0, 0, 1);
        add(0, 1, 0, 0,   0, 1, 1, 0);
        add(0, 0, 0, 0,   0, 1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].load, vecs[i].en, vecs[i].reload_en, int'(vecs[i].d));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_q", i),    int'(bus.Q),    int'(vecs[i].exp_q));
            chk($sformatf("vec%0d_zero", i), int'(bus.ZERO), int'(vecs[i].exp_zero));
            chk($sformatf("vec%0d_done", i), int'(bus.DONE), int'(vecs[i].exp_done));
            chk($sformatf("vec%0d_busy", i), int'(bus.BUSY), int'(vecs[i].exp_busy));
        end

        // reset in the middle of a count, between clock edges
        drive(1, 0, 0, 5);
        @(posedge clk); #1;
        drive(0, 1, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_q", int'(bus.Q), 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q",    int'(bus.Q), 0);
        chk("async_rst_zero", int'(bus.ZERO), 1);
        chk("async_rst_busy", int'(bus.BUSY), 0);
        chk("async_rst_done", int'(bus.DONE), 0);
        @(posedge clk); #3 rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.DONE !== 1'b0 || bus.Q !== 8'd0) bad = 1'b1;
        end
        chk("post_rst_quiet", int'(bad), 0);

        // full-range load: 255 enabled cycles to expire, no wrap
        drive(1, 0, 0, 255);
        @(posedge clk); #1;
        chk("load255_q", int'(bus.Q), 255);
        drive(0, 1, 0, 0);
        cyc    = 0;
        bad    = 1'b0;
        prev_q = 255;
        while (bus.Q !== 8'd0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (int'(bus.Q) != prev_q - 1) bad = 1'b1;
            if (bus.DONE !== (bus.Q == 8'd0)) bad = 1'b1;
            prev_q = int'(bus.Q);
        end
        chk("load255_cycles", cyc, 255);
        chk("load255_step",   int'(bad), 0);
        @(posedge clk); #1;
        chk("load255_nowrap_q",    int'(bus.Q), 0);
        chk("load255_nowrap_done", int'(bus.DONE), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
